z3_slave_sequencer: RTL

//  Parametrised Zorro III slave-cycle sequencer: synchronises FCS_n/DS_n, selects one of NUM_REGIONS

---
 rtl/z3_slave_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/z3_slave_sequencer.sv
// rtl/z3_slave_sequencer.sv - Zorro III slave-cycle sequencer with region priority, timeout and burst.
// Optional multi-transfer bursts are enabled by defining Z3_BURST_EN.
module z3_slave_sequencer #(
  parameter int                     NUM_REGIONS    = 4,
  parameter int                     SYNC_STAGES    = 2,
  parameter int                     TIMEOUT_CYCLES = 64,
  parameter logic [NUM_REGIONS-1:0] BURST_MASK     = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FCS_n,
  input  logic [3:0]             DS_n,
  input  logic                   READ,
  input  logic                   DOE,
  input  logic                   validspace,
  input  logic                   bus_enable,
  input  logic [NUM_REGIONS-1:0] region_hit,
  input  logic [NUM_REGIONS-1:0] region_ack,
  input  logic                   MTCR_n,
  output logic [NUM_REGIONS-1:0] region_sel,
  output logic                   cycle_active,
  output logic                   data_phase,
  output logic                   dtack,
  output logic                   berr_req,
  output logic                   MTACK_n
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_ERR} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] fcs_sync;
  logic [SYNC_STAGES-1:0] mtcr_sync;
  logic [3:0]             ds_sync [SYNC_STAGES];
  logic                   fcs_s;
  logic                   mtcr_s;
  logic [3:0]             ds_s;
  logic [TW-1:0]          timer;
  logic                   burst_ok;
  logic [NUM_REGIONS-1:0] hit_onehot;
  logic                   hit_burst;
  logic                   sel_ack;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fcs_sync  <= '1;
      mtcr_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) ds_sync[i] <= 4'hF;
    end else begin
      fcs_sync   <= {fcs_sync[SYNC_STAGES-2:0], FCS_n};
      mtcr_sync  <= {mtcr_sync[SYNC_STAGES-2:0], MTCR_n};
      ds_sync[0] <= DS_n;
      for (int i = 1; i < SYNC_STAGES; i++) ds_sync[i] <= ds_sync[i-1];
    end
  end

  assign fcs_s  = fcs_sync[SYNC_STAGES-1];
  assign mtcr_s = mtcr_sync[SYNC_STAGES-1];
  assign ds_s   = ds_sync[SYNC_STAGES-1];

  // Isolate the lowest set bit: lower index wins when regions overlap.
  assign hit_onehot = region_hit & ((~region_hit) + NUM_REGIONS'(1));
  assign hit_burst  = |(hit_onehot & BURST_MASK);
  assign sel_ack    = |(region_ack & region_sel);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      region_sel   <= '0;
      cycle_active <= 1'b0;
      data_phase   <= 1'b0;
      dtack        <= 1'b0;
      berr_req     <= 1'b0;
      timer        <= '0;
      burst_ok     <= 1'b0;
`ifdef Z3_BURST_EN
      MTACK_n      <= 1'b1;
`endif
    end else if (state != S_IDLE && fcs_s) begin
      // FCS_n release ends every phase, and beats a same-cycle ack.
      state        <= S_IDLE;
      region_sel   <= '0;
      cycle_active <= 1'b0;
      data_phase   <= 1'b0;
      dtack        <= 1'b0;
      berr_req     <= 1'b0;
      burst_ok     <= 1'b0;
`ifdef Z3_BURST_EN
      MTACK_n      <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fcs_s && validspace && bus_enable && |region_hit) begin
            state        <= S_START;
            region_sel   <= hit_onehot;
            burst_ok     <= hit_burst;
            cycle_active <= 1'b1;
`ifdef Z3_BURST_EN
            MTACK_n      <= ~hit_burst;
`endif
          end
        end
        S_START: begin
          if (READ || (ds_s != 4'hF && DOE)) begin
            state      <= S_DATA;
            data_phase <= 1'b1;
            timer      <= '0;
          end
        end
        S_DATA: begin
          if (sel_ack) begin
            state      <= S_END;
            data_phase <= 1'b0;
            dtack      <= 1'b1;
          end else if (TIMEOUT_CYCLES != 0 && timer == TMAX) begin
            state      <= S_ERR;
            data_phase <= 1'b0;
            berr_req   <= 1'b1;
          end else if (timer != {TW{1'b1}}) begin
            timer <= timer + TW'(1);
          end
        end
        S_END: begin
`ifdef Z3_BURST_EN
          if (ds_s == 4'hF && !mtcr_s && burst_ok) begin
            state <= S_START;
            dtack <= 1'b0;
            timer <= '0;
          end
`endif
        end
        S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef Z3_BURST_EN
  logic unused_burst;
  assign unused_burst = &{1'b0, mtcr_s, burst_ok};
  assign MTACK_n      = 1'b1;
`endif

endmodule
